// File: rtl/des_pkg.sv
// Shared definitions for the DES block sequencer: state encoding,
// chaining-mode encoding and the default round count of the core.
package des_pkg;

  localparam int DES_ROUNDS = 16;

  typedef enum logic [3:0] {
    IDLE,
    RD1,
    RD2,
    RD3,
    ROUND,
    WR_LO,
    WR_HI,
    NEXT,
    DONE
  } desState_t;

  typedef enum logic {
    MODE_ECB = 1'b0,
    MODE_CBC = 1'b1
  } desMode_t;

endpackage

// File: rtl/des_cbc_chain.sv
// CBC chaining unit: holds the chaining value and applies the
// pre-core XOR (CBC encrypt) and post-core XOR (CBC decrypt).
// In ECB both paths pass straight through.
module des_cbc_chain
  import des_pkg::*;
(
  input  logic        dcm_clk,
  input  logic        reset,
  input  logic        loadIv,
  input  logic [63:0] iv,
  input  desMode_t    mode,
  input  logic        decrypt,
  input  logic [63:0] blockIn,
  input  logic [63:0] coreInReg,
  input  logic [63:0] coreOut,
  input  logic        advance,
  output logic [63:0] coreInNext,
  output logic [63:0] resultNext
);

  logic [63:0] chain;

  // Select the core input and the block result for the current mode/direction
  always_comb begin
    coreInNext = blockIn;
    resultNext = coreOut;
    if (mode == MODE_CBC) begin
      if (decrypt) begin
        resultNext = coreOut ^ chain;
      end else begin
        coreInNext = blockIn ^ chain;
      end
    end
  end

  // Chain register: iv at run start, then ciphertext of the block just finished.
  // When decrypting, the registered core input is the ciphertext block itself.
  always_ff @(posedge dcm_clk) begin
    if (reset) begin
      chain <= '0;
    end else if (loadIv) begin
      chain <= iv;
    end else if (advance && (mode == MODE_CBC)) begin
      chain <= decrypt ? coreInReg : coreOut;
    end
  end

endmodule

// File: rtl/des_block_seq.sv
// DES block sequencer: streams 64-bit blocks from an input RAM (two 32-bit
// words per block, low word first) through an external iterative DES core
// and writes results to an output RAM, in ECB or CBC mode.
module des_block_seq
  import des_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int ROUNDS = DES_ROUNDS
) (
  input  logic              dcm_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              decrypt,
  input  logic              cbc_en,
  input  logic [63:0]       iv,
  input  logic [ADDR_W-2:0] num_blocks,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              wr_en,
  output logic [63:0]       core_in,
  output logic [3:0]        core_round,
  input  logic [63:0]       core_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-2:0] blocks_done
);

  desState_t         state;
  desState_t         stateNext;
  desMode_t          modeReg;
  logic              decReg;
  logic [ADDR_W-2:0] numReg;
  logic [ADDR_W-2:0] blkIdx;
  logic [ADDR_W-2:0] blkIdxInc;
  logic [31:0]       loWord;
  logic [63:0]       resultReg;
  logic [63:0]       coreInNext;
  logic [63:0]       resultNext;
  logic              startAccept;
  logic              lastRound;
  logic              lastBlock;

  assign startAccept = (state == IDLE) && start;
  assign lastRound   = (core_round == 4'(ROUNDS - 1));
  assign blkIdxInc   = blkIdx + 1'b1;
  // A count of 0 wraps the block index all the way round, i.e. the full RAM.
  assign lastBlock   = (blkIdxInc == numReg);

  des_cbc_chain u_chain (
    .dcm_clk    (dcm_clk),
    .reset      (reset),
    .loadIv     (startAccept),
    .iv         (iv),
    .mode       (modeReg),
    .decrypt    (decReg),
    .blockIn    ({rd_data, loWord}),
    .coreInReg  (core_in),
    .coreOut    (core_out),
    .advance    ((state == ROUND) && lastRound),
    .coreInNext (coreInNext),
    .resultNext (resultNext)
  );

  // Next-state logic for the per-block read / round / write sequence
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = RD1;
      RD1:     stateNext = RD2;
      RD2:     stateNext = RD3;
      RD3:     stateNext = ROUND;
      ROUND:   if (lastRound) stateNext = WR_LO;
      WR_LO:   stateNext = WR_HI;
      WR_HI:   stateNext = NEXT;
      NEXT:    stateNext = lastBlock ? DONE : RD1;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Control registers: state, run configuration, block index and round counter
  always_ff @(posedge dcm_clk) begin
    if (reset) begin
      state      <= IDLE;
      modeReg    <= MODE_ECB;
      decReg     <= 1'b0;
      numReg     <= '0;
      blkIdx     <= '0;
      core_round <= '0;
      core_in    <= '0;
    end else begin
      state <= stateNext;
      if (startAccept) begin
        modeReg <= desMode_t'(cbc_en);
        decReg  <= decrypt;
        numReg  <= num_blocks;
        blkIdx  <= '0;
      end
      if (state == NEXT) begin
        blkIdx <= blkIdxInc;
      end
      if (state == RD3) begin
        core_round <= '0;
        core_in    <= coreInNext;
      end else if ((state == ROUND) && !lastRound) begin
        core_round <= core_round + 4'd1;
      end
    end
  end

  // Datapath captures: low input word, and the block result on the final round
  always_ff @(posedge dcm_clk) begin
    if (state == RD2) begin
      loWord <= rd_data;
    end
    if ((state == ROUND) && lastRound) begin
      resultReg <= resultNext;
    end
  end

  // RAM ports and status decoded from the current state
  always_comb begin
    rd_addr     = {blkIdx, (state == RD2)};
    wr_addr     = {blkIdx, (state == WR_HI)};
    wr_en       = (state == WR_LO) || (state == WR_HI);
    wr_data     = (state == WR_HI) ? resultReg[63:32] : resultReg[31:0];
    busy        = (state != IDLE);
    done        = (state == DONE);
    blocks_done = blkIdx;
  end

endmodule
